axis_segmented_bram_writer: RTL and testbench

Write-side counterpart of the segmented BRAM stream reader. It accepts an AXI-Stream slave input and writes each beat into one BRAM segment `[cfg_start .. cfg_end]`, optionally relocated by a buffer offset for double buffering. When the segment is filled it raises a done handshake. Sits between acquisition/DSP streams and the shared port-A of a BRAM that the reader or PS later drains.

---
 rtl/axis_segmented_bram_writer_pkg.sv | 23 ++
 rtl/axis_segmented_bram_writer_bram_write_stage.sv | 49 ++++
 rtl/axis_segmented_bram_writer.sv | 153 +++++++++++++++
 tb/tb_axis_segmented_bram_writer.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_segmented_bram_writer_pkg.sv
// ============================================================================
// Module      : axis_segmented_bram_writer_pkg
// Description : Shared types and helpers for the segmented BRAM stream writer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axis_segmented_bram_writer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Byte-enable count for a given BRAM word width.
  function automatic int we_width(input int data_width);
    return data_width / 8;
  endfunction

endpackage

`default_nettype wire

// File: rtl/axis_segmented_bram_writer_bram_write_stage.sv
// ============================================================================
// Module      : axis_segmented_bram_writer_bram_write_stage
// Description : Registered BRAM write port stage with base-offset address add.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_segmented_bram_writer_bram_write_stage #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int WE_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_wr,
  input  logic [ADDR_WIDTH-1:0] i_base,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [WE_WIDTH-1:0]   o_we
);

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic [WE_WIDTH-1:0]   r_we;

  // Address and data hold between writes; only the enables return to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
      r_data <= '0;
      r_we   <= '0;
    end else begin
      r_we <= {WE_WIDTH{i_wr}};
      if (i_wr) begin
        r_addr <= i_base + i_addr;
        r_data <= i_data;
      end
    end
  end

  assign o_addr = r_addr;
  assign o_data = r_data;
  assign o_we   = r_we;

endmodule

`default_nettype wire

// File: rtl/axis_segmented_bram_writer.sv
// ============================================================================
// Module      : axis_segmented_bram_writer
// Description : AXI-Stream to BRAM segment writer with optional double buffering.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axis_segmented_bram_writer
  import axis_segmented_bram_writer_pkg::*;
#(
  parameter int    AXIS_TDATA_WIDTH = 32,
  parameter int    BRAM_DATA_WIDTH  = 32,
  parameter int    BRAM_ADDR_WIDTH  = 10,
  parameter string CONTINUOUS       = "FALSE"
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic                         arm,
  input  logic [BRAM_ADDR_WIDTH-1:0]   cfg_start,
  input  logic [BRAM_ADDR_WIDTH-1:0]   cfg_end,
  input  logic [BRAM_ADDR_WIDTH-1:0]   buffer_offset,
  input  logic                         buffer_select,
  output logic [BRAM_ADDR_WIDTH-1:0]   sts_addr,
  output logic [BRAM_ADDR_WIDTH:0]     sts_count,
  output logic                         sts_error,
  output logic                         s_axis_tready,
  input  logic [AXIS_TDATA_WIDTH-1:0]  s_axis_tdata,
  input  logic                         s_axis_tvalid,
  input  logic                         s_axis_tlast,
  output logic                         m_axis_done_tvalid,
  input  logic                         m_axis_done_tready,
  output logic                         bram_porta_clk,
  output logic                         bram_porta_rst,
  output logic [BRAM_ADDR_WIDTH-1:0]   bram_porta_addr,
  output logic [BRAM_DATA_WIDTH-1:0]   bram_porta_wrdata,
  output logic [BRAM_DATA_WIDTH/8-1:0] bram_porta_we
);

  localparam int c_we_width   = we_width(BRAM_DATA_WIDTH);
  localparam bit c_continuous = (CONTINUOUS == "TRUE");

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [BRAM_ADDR_WIDTH-1:0] r_start;
  logic [BRAM_ADDR_WIDTH-1:0] r_end;
  logic [BRAM_ADDR_WIDTH-1:0] r_base;
  logic [BRAM_ADDR_WIDTH-1:0] r_addr;
  logic [BRAM_ADDR_WIDTH-1:0] r_addr_inc;
  logic [BRAM_ADDR_WIDTH:0]   r_count;
  logic                       r_error;

  logic w_tready;
  logic w_done_valid;
  logic w_beat;
  logic w_at_end;
  logic w_arm_ok;
  logic w_arm_bad;
  logic w_finish;
  logic w_short;

  assign w_arm_ok  = (r_state == ST_IDLE) && arm && (cfg_start <= cfg_end);
  assign w_arm_bad = (r_state == ST_IDLE) && arm && (cfg_start > cfg_end);
  assign w_beat    = s_axis_tvalid && w_tready;
  assign w_at_end  = (r_addr == r_end);
  assign w_finish  = !c_continuous && w_beat && w_at_end;
  assign w_short   = !c_continuous && w_beat && s_axis_tlast && !w_at_end;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_arm_ok)              w_state_nxt = ST_RUN;
      ST_RUN:  if (w_finish || w_short)   w_state_nxt = ST_DONE;
      ST_DONE: if (m_axis_done_tready)    w_state_nxt = ST_IDLE;
      default:                            w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_tready     = 1'b0;
    w_done_valid = 1'b0;
    case (r_state)
      ST_RUN:  w_tready     = 1'b1;
      ST_DONE: w_done_valid = 1'b1;
      default: ;
    endcase
  end

  // r_addr_inc tracks r_addr+1 so the end compare and increment stay one level deep.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_start    <= '0;
      r_end      <= '0;
      r_base     <= '0;
      r_addr     <= '0;
      r_addr_inc <= '0;
      r_count    <= '0;
      r_error    <= 1'b0;
    end else if (w_arm_ok) begin
      r_start    <= cfg_start;
      r_end      <= cfg_end;
      r_base     <= buffer_select ? buffer_offset : '0;
      r_addr     <= cfg_start;
      r_addr_inc <= cfg_start + 1'b1;
      r_count    <= '0;
      r_error    <= 1'b0;
    end else begin
      if (w_arm_bad) r_error <= 1'b1;
      if (w_beat) begin
        if (c_continuous && w_at_end) begin
          r_addr     <= r_start;
          r_addr_inc <= r_start + 1'b1;
        end else begin
          r_addr     <= r_addr_inc;
          r_addr_inc <= r_addr_inc + 1'b1;
        end
        if (r_count != '1) r_count <= r_count + 1'b1;
        if (w_short)       r_error <= 1'b1;
      end
    end
  end

  axis_segmented_bram_writer_bram_write_stage #(
    .ADDR_WIDTH (BRAM_ADDR_WIDTH),
    .DATA_WIDTH (BRAM_DATA_WIDTH),
    .WE_WIDTH   (c_we_width)
  ) u_write_stage (
    .clk    (aclk),
    .rst_n  (aresetn),
    .i_wr   (w_beat),
    .i_base (r_base),
    .i_addr (r_addr),
    .i_data (s_axis_tdata),
    .o_addr (bram_porta_addr),
    .o_data (bram_porta_wrdata),
    .o_we   (bram_porta_we)
  );

  assign s_axis_tready      = w_tready;
  assign m_axis_done_tvalid = w_done_valid;
  assign sts_addr           = r_addr;
  assign sts_count          = r_count;
  assign sts_error          = r_error;
  assign bram_porta_clk     = aclk;
  assign bram_porta_rst     = ~aresetn;

endmodule

`default_nettype wire

// File: tb/tb_axis_segmented_bram_writer.sv
// ============================================================================
// Module      : tb_axis_segmented_bram_writer
// Description : Self-checking bench for one-shot and continuous writer instances.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_axis_segmented_bram_writer;

  localparam int AW  = 10;
  localparam int DW  = 32;
  localparam int WEW = DW / 8;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  // Index 0: CONTINUOUS="FALSE", index 1: CONTINUOUS="TRUE"
  logic          arm [2];
  logic [AW-1:0] cfg_start [2];
  logic [AW-1:0] cfg_end [2];
  logic [AW-1:0] buffer_offset [2];
  logic          buffer_select [2];
  logic [AW-1:0] sts_addr [2];
  logic [AW:0]   sts_count [2];
  logic          sts_error [2];
  logic          tready [2];
  logic [DW-1:0] tdata [2];
  logic          tvalid [2];
  logic          tlast [2];
  logic          done_v [2];
  logic          done_r [2];
  logic          pclk [2];
  logic          prst [2];
  logic [AW-1:0] paddr [2];
  logic [DW-1:0] pdata [2];
  logic [WEW-1:0] pwe [2];

  axis_segmented_bram_writer #(
    .AXIS_TDATA_WIDTH(DW), .BRAM_DATA_WIDTH(DW), .BRAM_ADDR_WIDTH(AW), .CONTINUOUS("FALSE")
  ) u_dut_oneshot (
    .aclk(aclk), .aresetn(aresetn), .arm(arm[0]),
    .cfg_start(cfg_start[0]), .cfg_end(cfg_end[0]),
    .buffer_offset(buffer_offset[0]), .buffer_select(buffer_select[0]),
    .sts_addr(sts_addr[0]), .sts_count(sts_count[0]), .sts_error(sts_error[0]),
    .s_axis_tready(tready[0]), .s_axis_tdata(tdata[0]),
    .s_axis_tvalid(tvalid[0]), .s_axis_tlast(tlast[0]),
    .m_axis_done_tvalid(done_v[0]), .m_axis_done_tready(done_r[0]),
    .bram_porta_clk(pclk[0]), .bram_porta_rst(prst[0]),
    .bram_porta_addr(paddr[0]), .bram_porta_wrdata(pdata[0]), .bram_porta_we(pwe[0])
  );

  axis_segmented_bram_writer #(
    .AXIS_TDATA_WIDTH(DW), .BRAM_DATA_WIDTH(DW), .BRAM_ADDR_WIDTH(AW), .CONTINUOUS("TRUE")
  ) u_dut_cont (
    .aclk(aclk), .aresetn(aresetn), .arm(arm[1]),
    .cfg_start(cfg_start[1]), .cfg_end(cfg_end[1]),
    .buffer_offset(buffer_offset[1]), .buffer_select(buffer_select[1]),
    .sts_addr(sts_addr[1]), .sts_count(sts_count[1]), .sts_error(sts_error[1]),
    .s_axis_tready(tready[1]), .s_axis_tdata(tdata[1]),
    .s_axis_tvalid(tvalid[1]), .s_axis_tlast(tlast[1]),
    .m_axis_done_tvalid(done_v[1]), .m_axis_done_tready(done_r[1]),
    .bram_porta_clk(pclk[1]), .bram_porta_rst(prst[1]),
    .bram_porta_addr(paddr[1]), .bram_porta_wrdata(pdata[1]), .bram_porta_we(pwe[1])
  );

  typedef struct {
    int cont;
    int start;
    int end_;
    int sel;
    int off;
    int n_offer;
    int tlast_at;
    int gap;
    int hold;
    int exp_count;
    int exp_err;
    int exp_first;
  } rec_t;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state for the segment currently armed
  int m_start, m_end, m_base, m_len;
  int first_addr;
  int g_acc;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int exp_phys(input int cont, input int i);
    int seg;
    seg = cont ? m_start + (i % m_len) : m_start + i;
    return (m_base + seg) % (1 << AW);
  endfunction

  function automatic bit gap_ok(input int gap, input int cyc);
    case (gap)
      0:       return 1'b1;
      1:       return (cyc % 2) == 0;
      default: return ($urandom % 3) != 0;
    endcase
  endfunction

  task automatic check_wr(input int d, input bit pend, input int pa, input logic [DW-1:0] pdv);
    if (pend) begin
      chk("wr_we", pwe[d], {WEW{1'b1}});
      chk("wr_addr", paddr[d], pa);
      chk("wr_data", pdata[d], pdv);
      if (first_addr < 0) first_addr = int'(paddr[d]);
    end else begin
      chk("idle_we", pwe[d], 0);
    end
  endtask

  task automatic do_arm(input int d, input int s, input int e, input int sel, input int off);
    cfg_start[d] = s[AW-1:0];
    cfg_end[d] = e[AW-1:0];
    buffer_select[d] = sel[0];
    buffer_offset[d] = off[AW-1:0];
    arm[d] = 1'b1;
    @(posedge aclk); #1;
    arm[d] = 1'b0;
    m_start = s; m_end = e; m_base = sel ? off : 0; m_len = e - s + 1;
    // Scramble the config after arming; the latched copy must be used
    cfg_start[d] = AW'($urandom);
    cfg_end[d] = AW'($urandom);
    buffer_select[d] = 1'($urandom);
    buffer_offset[d] = AW'($urandom);
  endtask

  task automatic drive_segment(input int d, input int cont, input int n_offer,
                               input int tlast_at, input int gap);
    int i = 0;
    int cyc = 0;
    bit pend = 0;
    bit stop = 0;
    int pa = 0;
    logic [DW-1:0] pdv = '0;
    first_addr = -1;
    while (!stop) begin
      tvalid[d] = (cont ? (i < n_offer) : 1'b1) && gap_ok(gap, cyc);
      tdata[d] = $urandom;
      tlast[d] = (i == tlast_at);
      @(negedge aclk);
      check_wr(d, pend, pa, pdv);
      pend = tvalid[d] && tready[d];
      if (pend) begin
        pa = exp_phys(cont, i);
        pdv = tdata[d];
        i++;
      end
      @(posedge aclk); #1;
      cyc++;
      if (cont ? (i >= n_offer) : (done_v[d] == 1'b1)) stop = 1;
      else if (cyc > 5000) begin
        chk("segment_timeout", 1, 0);
        stop = 1;
      end
    end
    tvalid[d] = (cont == 0);
    tlast[d] = 1'b0;
    @(negedge aclk);
    check_wr(d, pend, pa, pdv);
    if (cont == 0) chk("tready_after_end", tready[d], 0);
    tvalid[d] = 1'b0;
    g_acc = i;
  endtask

  task automatic finish_done(input int d, input int hold);
    chk("done_valid", done_v[d], 1);
    repeat (hold) begin @(posedge aclk); #1; end
    if (hold > 0) begin
      @(negedge aclk);
      chk("done_held", done_v[d], 1);
      chk("done_we", pwe[d], 0);
    end
    done_r[d] = 1'b1;
    @(posedge aclk); #1;
    done_r[d] = 1'b0;
    @(negedge aclk);
    chk("done_acked", done_v[d], 0);
    chk("idle_tready", tready[d], 0);
    @(posedge aclk); #1;
  endtask

  task automatic pulse_reset();
    @(posedge aclk); #2;
    aresetn = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk); #1;
  endtask

  task automatic run_scenario(input rec_t r);
    int d;
    int exp_n;
    d = r.cont;
    do_arm(d, r.start, r.end_, r.sel, r.off);
    @(negedge aclk);
    chk("arm_sts_addr", sts_addr[d], r.start);
    chk("arm_sts_count", sts_count[d], 0);
    chk("arm_sts_error", sts_error[d], 0);
    chk("arm_tready", tready[d], 1);
    @(posedge aclk); #1;
    drive_segment(d, r.cont, r.n_offer, r.tlast_at, r.gap);
    if (r.cont != 0) exp_n = r.n_offer;
    else if (r.tlast_at >= 0 && r.tlast_at < m_len - 1) exp_n = r.tlast_at + 1;
    else exp_n = m_len;
    chk("beats_accepted", g_acc, exp_n);
    chk("sts_count", sts_count[d], r.exp_count);
    chk("sts_error", sts_error[d], r.exp_err);
    chk("first_addr", first_addr, r.exp_first);
    if (r.cont != 0) begin
      chk("cont_no_done", done_v[d], 0);
      chk("cont_sts_addr", sts_addr[d], m_start + (r.n_offer % m_len));
      pulse_reset();
    end else begin
      finish_done(d, r.hold);
    end
  endtask

  rec_t tbl [10];

  initial begin
    rec_t r;
    for (int d = 0; d < 2; d++) begin
      arm[d] = 0; cfg_start[d] = '0; cfg_end[d] = '0; buffer_offset[d] = '0;
      buffer_select[d] = 0; tdata[d] = '0; tvalid[d] = 0; tlast[d] = 0; done_r[d] = 0;
    end
    //          cont start end  sel off  n     tl  gap hold cnt   err first
    tbl[0] = '{0,   4,    7,   1,  512, 0,    -1, 0,  0,   4,    0,  516};
    tbl[1] = '{0,   10,   15,  0,  300, 0,    -1, 1,  5,   6,    0,  10};
    tbl[2] = '{1,   0,    2,   0,  0,   7,    1,  0,  0,   7,    0,  0};
    tbl[3] = '{0,   0,    5,   0,  0,   0,    2,  0,  0,   3,    1,  0};
    tbl[4] = '{0,   0,    7,   1,  1020,0,    -1, 0,  0,   8,    0,  1020};
    tbl[5] = '{0,   20,   22,  0,  0,   0,    2,  0,  0,   3,    0,  20};
    tbl[6] = '{0,   100,  100, 1,  5,   0,    -1, 0,  1,   1,    0,  105};
    tbl[7] = '{1,   5,    8,   1,  1022,10,   -1, 2,  0,   10,   0,  3};
    tbl[8] = '{0,   1021, 1023,0,  0,   0,    -1, 2,  2,   3,    0,  1021};
    tbl[9] = '{1,   0,    1023,0,  0,   2050, -1, 0,  0,   2047, 0,  0};

    #2;
    for (int d = 0; d < 2; d++) begin
      chk("rst_we", pwe[d], 0);
      chk("rst_addr", paddr[d], 0);
      chk("rst_wrdata", pdata[d], 0);
      chk("rst_tready", tready[d], 0);
      chk("rst_done", done_v[d], 0);
      chk("rst_count", sts_count[d], 0);
      chk("rst_error", sts_error[d], 0);
      chk("rst_porta_rst", prst[d], 1);
      chk("rst_porta_clk", pclk[d], aclk);
    end
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk); #1;
    chk("porta_rst_released", prst[0], 0);

    // Reversed bounds: error flagged, writer never leaves IDLE
    cfg_start[0] = 10'd9; cfg_end[0] = 10'd3; arm[0] = 1'b1;
    @(posedge aclk); #1;
    arm[0] = 1'b0;
    tvalid[0] = 1'b1;
    @(negedge aclk);
    chk("bad_arm_error", sts_error[0], 1);
    chk("bad_arm_tready", tready[0], 0);
    @(posedge aclk); #1;
    @(negedge aclk);
    chk("bad_arm_no_write", pwe[0], 0);
    chk("bad_arm_count", sts_count[0], 0);
    tvalid[0] = 1'b0;
    @(posedge aclk); #1;

    for (int k = 0; k < 10; k++) run_scenario(tbl[k]);

    // Arm while in RUN must not disturb the active segment
    do_arm(0, 30, 32, 0, 0);
    cfg_start[0] = 10'd200; cfg_end[0] = 10'd201; arm[0] = 1'b1;
    @(posedge aclk); #1;
    arm[0] = 1'b0;
    drive_segment(0, 0, 0, -1, 0);
    chk("rearm_beats", g_acc, 3);
    chk("rearm_first", first_addr, 30);
    finish_done(0, 0);

    // Asynchronous abort after two beats of an eight-word segment
    do_arm(0, 40, 47, 1, 100);
    tvalid[0] = 1'b1;
    repeat (2) begin
      tdata[0] = $urandom;
      @(posedge aclk); #1;
    end
    #1 aresetn = 1'b0;
    #1;
    chk("abort_we", pwe[0], 0);
    chk("abort_addr", paddr[0], 0);
    chk("abort_tready", tready[0], 0);
    chk("abort_done", done_v[0], 0);
    chk("abort_count", sts_count[0], 0);
    chk("abort_porta_rst", prst[0], 1);
    tvalid[0] = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk); #1;
    @(negedge aclk);
    chk("abort_no_done", done_v[0], 0);
    @(posedge aclk); #1;
    r = '{0, 40, 47, 0, 0, 0, -1, 0, 0, 8, 0, 40};
    run_scenario(r);

    // Randomized segments with expectations from the reference rules
    for (int k = 0; k < 14; k++) begin
      int len;
      r.cont = int'($urandom % 2);
      r.start = int'($urandom % 1024);
      len = 1 + int'($urandom % 12);
      r.end_ = (r.start + len - 1 > 1023) ? 1023 : r.start + len - 1;
      len = r.end_ - r.start + 1;
      r.sel = int'($urandom % 2);
      r.off = int'($urandom % 1024);
      r.n_offer = 1 + int'($urandom % 20);
      r.tlast_at = (($urandom % 3) == 0) ? int'($urandom % len) : -1;
      r.gap = int'($urandom % 3);
      r.hold = int'($urandom % 4);
      if (r.cont != 0) begin
        r.exp_count = r.n_offer;
        r.exp_err = 0;
      end else if (r.tlast_at >= 0 && r.tlast_at < len - 1) begin
        r.exp_count = r.tlast_at + 1;
        r.exp_err = 1;
      end else begin
        r.exp_count = len;
        r.exp_err = 0;
      end
      r.exp_first = ((r.sel != 0 ? r.off : 0) + r.start) % 1024;
      run_scenario(r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
